// File: rtl/serial_framer_pkg.sv
// serial_framer_pkg: shared state encoding and default frame width for the serial framer
package serial_framer_pkg;
  localparam int DATA_BITS_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2,
    HOLD = 2'd3
  } state_t;
endpackage

// File: rtl/serial_framer_if.sv
// serial_framer_if: serial line, sample strobe, acknowledge and received-frame outputs
interface serial_framer_if
  import serial_framer_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic serial_in;
  logic sample_en;
  logic ack;
  logic [DATA_BITS-1:0] data_out;
  logic data_valid;
  logic frame_err;
  logic overrun;
  logic busy;
  modport master (
    output serial_in, sample_en, ack,
    input  data_out, data_valid, frame_err, overrun, busy
  );
  modport slave (
    input  serial_in, sample_en, ack,
    output data_out, data_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/sipo_shift.sv
// sipo_shift: right-shifting serial-in parallel-out register, new bit enters at the MSB
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (!reset_b || clear) q <= '0;
    else if (shift_en) q <= {din, q[WIDTH-1:1]};
endmodule

// File: rtl/serial_framer.sv
// serial_framer: start/data/stop frame receiver with hold-until-ack and sticky overrun
module serial_framer
  import serial_framer_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input logic clk,
  input logic reset_b,
  serial_framer_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  state_t state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [DATA_BITS-1:0] sh_q, data_q;
  logic valid_q, err_q, ovr_q;
  logic nxt_valid, nxt_err, nxt_ovr;
  logic sh_en, sh_clr, load, start;
  assign start = bus.sample_en && !bus.serial_in;
  sipo_shift #(.WIDTH(DATA_BITS)) u_shift (
    .clk(clk),
    .reset_b(reset_b),
    .shift_en(sh_en),
    .clear(sh_clr),
    .din(bus.serial_in),
    .q(sh_q)
  );
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_valid = valid_q;
    nxt_err = err_q;
    nxt_ovr = ovr_q;
    sh_en = 1'b0;
    sh_clr = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt_state = DATA;
        nxt_cnt = '0;
        sh_clr = 1'b1;
      end
      DATA: if (bus.sample_en) begin
        sh_en = 1'b1;
        nxt_cnt = cnt + 1'b1;
        nxt_state = (cnt == LAST) ? STOP : DATA;
      end
      STOP: if (bus.sample_en) begin
        load = 1'b1;
        nxt_valid = 1'b1;
        nxt_err = !bus.serial_in;
        nxt_state = HOLD;
      end
      HOLD: if (bus.ack) begin
        // a start bit arriving with the ack begins the next frame immediately
        nxt_valid = 1'b0;
        nxt_err = 1'b0;
        nxt_ovr = 1'b0;
        nxt_cnt = '0;
        sh_clr = start;
        nxt_state = start ? DATA : IDLE;
      end else if (start) nxt_ovr = 1'b1;
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_b) begin
      state <= IDLE;
      cnt <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      if (load) data_q <= sh_q;
      valid_q <= nxt_valid;
      err_q <= nxt_err;
      ovr_q <= nxt_ovr;
    end
  assign bus.data_out = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.overrun = ovr_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_serial_framer.sv
// tb_serial_framer: directed scenario tasks with hand-computed expectations for serial_framer
module tb_serial_framer;
  logic clk;
  logic reset_b;
  int cmp;
  int err;
  serial_framer_if #(.DATA_BITS(8)) bus ();
  serial_framer #(.DATA_BITS(8)) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic s, input logic e, input logic a);
    bus.serial_in = s;
    bus.sample_en = e;
    bus.ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [15:0] v, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      step(v[i], 1'b1, 1'b0);
      if (gap) step(~v[i], 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    cmp++; if (bus.data_out !== 8'h00) begin err++; $display("FAIL reset_data: got %h exp 00", bus.data_out); end
    cmp++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b exp 0", bus.data_valid); end
    cmp++; if (bus.frame_err !== 1'b0) begin err++; $display("FAIL reset_err: got %b exp 0", bus.frame_err); end
    cmp++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL reset_ovr: got %b exp 0", bus.overrun); end
    cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    reset_b = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL idle_stays: got %b exp 0", bus.busy); end
  endtask

  task automatic test_basic;
    logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(f[i], 1'b1, 1'b0);
      if (i == 0) begin
        cmp++; if (bus.busy !== 1'b1) begin err++; $display("FAIL basic_busy: got %b exp 1", bus.busy); end
      end
      if (i == 8) begin
        cmp++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL basic_early_valid: got %b exp 0", bus.data_valid); end
      end
    end
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL basic_valid: got %b exp 1", bus.data_valid); end
    cmp++; if (bus.data_out !== 8'hA5) begin err++; $display("FAIL basic_data: got %h exp a5", bus.data_out); end
    cmp++; if (bus.frame_err !== 1'b0) begin err++; $display("FAIL basic_err: got %b exp 0", bus.frame_err); end
    step(1'b1, 1'b0, 1'b0);
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL basic_hold: got %b exp 1", bus.data_valid); end
    step(1'b1, 1'b0, 1'b1);
    cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL basic_ack_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_frame_err;
    drive_bits({6'd0, 1'b0, 8'hA5, 1'b0}, 10, 1'b0);
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL ferr_valid: got %b exp 1", bus.data_valid); end
    cmp++; if (bus.data_out !== 8'hA5) begin err++; $display("FAIL ferr_data: got %h exp a5", bus.data_out); end
    cmp++; if (bus.frame_err !== 1'b1) begin err++; $display("FAIL ferr_err: got %b exp 1", bus.frame_err); end
    step(1'b1, 1'b1, 1'b1);
    cmp++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL ferr_ack_valid: got %b exp 0", bus.data_valid); end
    cmp++; if (bus.frame_err !== 1'b0) begin err++; $display("FAIL ferr_ack_err: got %b exp 0", bus.frame_err); end
    cmp++; if (bus.data_out !== 8'hA5) begin err++; $display("FAIL ferr_ack_data: got %h exp a5", bus.data_out); end
  endtask

  task automatic test_gapped;
    logic [9:0] f;
    f = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(f[i], 1'b1, 1'b0);
      step(~f[i], 1'b0, 1'b0);
      if (i == 0) begin
        cmp++; if (bus.busy !== 1'b1) begin err++; $display("FAIL gap_busy: got %b exp 1", bus.busy); end
      end
      if (i == 8) begin
        cmp++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL gap_early_valid: got %b exp 0", bus.data_valid); end
      end
    end
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL gap_valid: got %b exp 1", bus.data_valid); end
    cmp++; if (bus.data_out !== 8'h3C) begin err++; $display("FAIL gap_data: got %h exp 3c", bus.data_out); end
    cmp++; if (bus.frame_err !== 1'b0) begin err++; $display("FAIL gap_err: got %b exp 0", bus.frame_err); end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_overrun;
    drive_bits({6'd0, 1'b1, 8'h5A, 1'b0}, 10, 1'b0);
    cmp++; if (bus.data_out !== 8'h5A) begin err++; $display("FAIL ovr_data0: got %h exp 5a", bus.data_out); end
    step(1'b0, 1'b1, 1'b0);
    cmp++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL ovr_set: got %b exp 1", bus.overrun); end
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL ovr_valid: got %b exp 1", bus.data_valid); end
    drive_bits(16'h00FF, 9, 1'b0);
    cmp++; if (bus.data_out !== 8'h5A) begin err++; $display("FAIL ovr_data: got %h exp 5a", bus.data_out); end
    cmp++; if (bus.overrun !== 1'b1) begin err++; $display("FAIL ovr_sticky: got %b exp 1", bus.overrun); end
    step(1'b1, 1'b1, 1'b1);
    cmp++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL ovr_clear: got %b exp 0", bus.overrun); end
    cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL ovr_idle: got %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    drive_bits({6'd0, 1'b1, 8'h12, 1'b0}, 10, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    cmp++; if (bus.busy !== 1'b1) begin err++; $display("FAIL b2b_busy: got %b exp 1", bus.busy); end
    cmp++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL b2b_valid_clr: got %b exp 0", bus.data_valid); end
    cmp++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL b2b_ovr0: got %b exp 0", bus.overrun); end
    drive_bits({7'd0, 1'b1, 8'hFF}, 9, 1'b0);
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL b2b_valid: got %b exp 1", bus.data_valid); end
    cmp++; if (bus.data_out !== 8'hFF) begin err++; $display("FAIL b2b_data: got %h exp ff", bus.data_out); end
    cmp++; if (bus.overrun !== 1'b0) begin err++; $display("FAIL b2b_ovr: got %b exp 0", bus.overrun); end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    drive_bits({11'd0, 4'b1011, 1'b0}, 5, 1'b0);
    reset_b = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    cmp++; if (bus.data_out !== 8'h00) begin err++; $display("FAIL mid_data: got %h exp 00", bus.data_out); end
    cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL mid_busy: got %b exp 0", bus.busy); end
    cmp++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL mid_valid: got %b exp 0", bus.data_valid); end
    reset_b = 1'b1;
    drive_bits({6'd0, 1'b1, 8'h81, 1'b0}, 10, 1'b0);
    cmp++; if (bus.data_out !== 8'h81) begin err++; $display("FAIL mid_next_data: got %h exp 81", bus.data_out); end
    cmp++; if (bus.data_valid !== 1'b1) begin err++; $display("FAIL mid_next_valid: got %b exp 1", bus.data_valid); end
    cmp++; if (bus.frame_err !== 1'b0) begin err++; $display("FAIL mid_next_err: got %b exp 0", bus.frame_err); end
  endtask

  initial begin
    cmp = 0;
    err = 0;
    reset_b = 1'b0;
    bus.serial_in = 1'b1;
    bus.sample_en = 1'b0;
    bus.ack = 1'b0;
    test_reset;
    test_basic;
    test_frame_err;
    test_gapped;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
